dmem_responder: RTL and testbench

//  Memory-side responder for the lane load/store path: consumes the effective

---
 rtl/dmem_responder.sv | 186 ++++++++++++++++++
 tb/tb_dmem_responder.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder
//   Memory-side responder for the lane load/store path. Takes the AGU's byte
//   address, does the word access on a local scratchpad, and returns load data
//   or a store acknowledge in acceptance order. Both sides use valid/ready.
//
//   Pipeline:
//     accept edge : store writes the scratchpad / load reads it into S1
//     next edge   : S1 moves into the response FIFO, whose head drives rsp_*
//
//   Occupancy (S1 plus FIFO entries) equals the number of accepted requests
//   whose response has not been consumed yet. New requests are refused while
//   that count is at RSP_DEPTH. S1 therefore always finds room in the FIFO, so
//   the pipe never has to stall internally.
module dmem_responder #(
    parameter int DATA_W    = 32,
    parameter int MEM_AW    = 10,
    parameter int TAG_W     = 5,
    parameter int RSP_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    // request side (from LSU issue)
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [DATA_W-1:0] req_addr_i,
    input  logic              req_we_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    input  logic [TAG_W-1:0]  req_tag_i,
    // response side (to writeback)
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_data_o,
    output logic [TAG_W-1:0]  rsp_tag_o,
    output logic              rsp_err_o
);

    localparam int MEM_WORDS = 1 << MEM_AW;
    localparam int CNT_W     = $clog2(RSP_DEPTH + 1);
    localparam int PTR_W     = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

    localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(RSP_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(RSP_DEPTH - 1);

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic              req_fire;
    logic              req_misaligned;
    logic              req_out_of_range;
    logic              req_err;
    logic [MEM_AW-1:0] req_idx;

    assign req_fire         = req_valid_i && req_ready_o;
    assign req_misaligned   = (req_addr_i[1:0] != 2'b00);
    assign req_out_of_range = ((req_addr_i >> (MEM_AW + 2)) != '0);
    assign req_err          = req_misaligned || req_out_of_range;
    assign req_idx          = req_addr_i[MEM_AW+1:2];

    // ------------------------------------------------------------------
    // Scratchpad
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem [MEM_WORDS];
    logic [DATA_W-1:0] mem_rdata;

    // Single-port scratchpad: store writes, load reads into the S1 data register.
    // NOTE: no reset on the array or its read register. This keeps it mappable to
    // block RAM, and stored data survives a reset. S1 flags qualify mem_rdata.
    always_ff @(posedge clk) begin
        if (req_fire && !req_err) begin
            if (req_we_i) begin
                mem[req_idx] <= req_wdata_i;
            end else begin
                mem_rdata <= mem[req_idx];
            end
        end
    end

    // ------------------------------------------------------------------
    // Pipe stage S1: control half of the accepted request
    // ------------------------------------------------------------------
    logic             s1_valid;
    logic             s1_we;
    logic             s1_err;
    logic [TAG_W-1:0] s1_tag;

    // Capture tag / kind / error of the request accepted on this edge.
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples pre-edge values regardless of block or statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_we    <= 1'b0;
            s1_err   <= 1'b0;
            s1_tag   <= '0;
        end else begin
            s1_valid <= req_fire;
            if (req_fire) begin
                s1_we  <= req_we_i;
                s1_err <= req_err;
                s1_tag <= req_tag_i;
            end
        end
    end

    // Stores and faulting accesses return zero data.
    logic [DATA_W-1:0] push_data;
    assign push_data = (s1_we || s1_err) ? '0 : mem_rdata;

    // ------------------------------------------------------------------
    // Response FIFO
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] fifo_data [RSP_DEPTH];
    logic [TAG_W-1:0]  fifo_tag  [RSP_DEPTH];
    logic              fifo_err  [RSP_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  fifo_count;
    logic              push;
    logic              pop;

    assign push = s1_valid;
    assign pop  = rsp_valid_o && rsp_ready_i;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // FIFO payload storage; validity is tracked by fifo_count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= push_data;
            fifo_tag[wr_ptr]  <= s1_tag;
            fifo_err[wr_ptr]  <= s1_err;
        end
    end

    // Pointers and count. A simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Flow control and outputs
    // ------------------------------------------------------------------
    logic [CNT_W:0] occ;

    // Ready uses only registered state, so it has no path from rsp_ready_i.
    assign occ         = {1'b0, fifo_count} + {{CNT_W{1'b0}}, s1_valid};
    assign req_ready_o = (occ < {1'b0, FIFO_FULL});
    assign rsp_valid_o = (fifo_count != '0);

    // The FIFO head drives the response. Outputs are forced to zero when idle.
    // NOTE: every output gets a default before the if. Any path that leaves one
    // unassigned would otherwise infer a latch.
    always_comb begin
        rsp_data_o = '0;
        rsp_tag_o  = '0;
        rsp_err_o  = 1'b0;
        if (rsp_valid_o) begin
            rsp_data_o = fifo_data[rd_ptr];
            rsp_tag_o  = fifo_tag[rd_ptr];
            rsp_err_o  = fifo_err[rd_ptr];
        end
    end

    // The occupancy bound guarantees S1 never pushes into a full FIFO.
    push_into_full: assert property (@(posedge clk) disable iff (reset)
        !(push && (fifo_count == FIFO_FULL)));

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder
//   Directed scenarios followed by randomized traffic. The reference model
//   tracks a word-array memory and a queue of expected responses. Each entry
//   is stamped with its accept edge. A response may be presented starting one
//   edge after its accept. Requests are accepted only while fewer than
//   RSP_DEPTH responses are outstanding.
module tb_dmem_responder;

    localparam int DATA_W    = 32;
    localparam int MEM_AW    = 10;
    localparam int TAG_W     = 5;
    localparam int RSP_DEPTH = 2;
    localparam int WORDS     = 1 << MEM_AW;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid_i;
    logic              req_ready_o;
    logic [DATA_W-1:0] req_addr_i;
    logic              req_we_i;
    logic [DATA_W-1:0] req_wdata_i;
    logic [TAG_W-1:0]  req_tag_i;
    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic [DATA_W-1:0] rsp_data_o;
    logic [TAG_W-1:0]  rsp_tag_o;
    logic              rsp_err_o;

    dmem_responder #(
        .DATA_W    (DATA_W),
        .MEM_AW    (MEM_AW),
        .TAG_W     (TAG_W),
        .RSP_DEPTH (RSP_DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_addr_i  (req_addr_i),
        .req_we_i    (req_we_i),
        .req_wdata_i (req_wdata_i),
        .req_tag_i   (req_tag_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_data_o  (rsp_data_o),
        .rsp_tag_o   (rsp_tag_o),
        .rsp_err_o   (rsp_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  tag;
    } req_t;

    typedef struct {
        logic [4:0]  tag;
        logic [31:0] data;
        logic        err;
        bit          known;
        int          stamp;
    } rsp_t;

    req_t        pending[$];
    rsp_t        exp_q[$];
    logic [31:0] mem_m   [WORDS];
    bit          known_m [WORDS];
    int          edge_cnt  = 0;
    int          total     = 0;
    int          bad       = 0;
    int          dut_acc   = 0;
    int          model_acc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit exp_ready();
        return exp_q.size() < RSP_DEPTH;
    endfunction

    function automatic bit exp_valid();
        return (exp_q.size() > 0) && ((edge_cnt - exp_q[0].stamp) >= 1);
    endfunction

    task automatic push_req(input bit we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [4:0] tag);
        req_t r;
        r.we    = we;
        r.addr  = addr;
        r.wdata = wdata;
        r.tag   = tag;
        pending.push_back(r);
    endtask

    // Apply the architectural effect of an accepted request to the model.
    task automatic accept(input req_t r);
        rsp_t e;
        int   idx;
        e.tag   = r.tag;
        e.stamp = edge_cnt;
        e.known = 1'b1;
        e.data  = 32'h0;
        e.err   = ((r.addr % 4) != 0) || (r.addr >= 32'h1000);
        if (!e.err) begin
            idx = int'(r.addr / 4);
            if (r.we) begin
                mem_m[idx]   = r.wdata;
                known_m[idx] = 1'b1;
            end else begin
                e.data  = mem_m[idx];
                e.known = known_m[idx];
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic check_outputs();
        check("req_ready", req_ready_o, exp_ready());
        check("rsp_valid", rsp_valid_o, exp_valid());
        if (exp_valid()) begin
            check("rsp_tag", rsp_tag_o, exp_q[0].tag);
            check("rsp_err", rsp_err_o, exp_q[0].err);
            if (exp_q[0].known) begin
                check("rsp_data", rsp_data_o, exp_q[0].data);
            end
        end
    endtask

    // One clock: drive at the falling edge, update the model at the rising
    // edge, and compare at the next falling edge.
    task automatic cycle(input bit vld_en, input bit rdy);
        bit   fire;
        bit   pop;
        req_t r;
        req_valid_i = vld_en && (pending.size() > 0);
        if (pending.size() > 0) begin
            r           = pending[0];
            req_we_i    = r.we;
            req_addr_i  = r.addr;
            req_wdata_i = r.wdata;
            req_tag_i   = r.tag;
        end
        rsp_ready_i = rdy;
        fire = req_valid_i && exp_ready();
        pop  = exp_valid() && rdy;
        if (req_valid_i && req_ready_o) dut_acc++;
        @(posedge clk);
        edge_cnt++;
        if (pop) void'(exp_q.pop_front());
        if (fire) begin
            accept(pending.pop_front());
            model_acc++;
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && (pending.size() > 0 || exp_q.size() > 0); i++) begin
            cycle(1'b1, 1'b1);
        end
        check("drain_empty", pending.size() + exp_q.size(), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int          w;
        int          k;

        reset       = 1'b1;
        req_valid_i = 1'b0;
        req_we_i    = 1'b0;
        req_addr_i  = '0;
        req_wdata_i = '0;
        req_tag_i   = '0;
        rsp_ready_i = 1'b0;
        for (int i = 0; i < WORDS; i++) begin
            mem_m[i]   = '0;
            known_m[i] = 1'b0;
        end

        // Reset state
        #12;
        check("rst_ready", req_ready_o, 1);
        check("rst_valid", rsp_valid_o, 0);
        check("rst_data",  rsp_data_o,  0);
        check("rst_tag",   rsp_tag_o,   0);
        check("rst_err",   rsp_err_o,   0);
        @(negedge clk);
        reset = 1'b0;

        // Prefill words 0..63 so that every later load has a defined value.
        for (int i = 0; i < 64; i++) begin
            push_req(1'b1, 32'(i * 4), $urandom, 5'(i));
        end
        drain();

        // 1: store then back-to-back load of the same word
        push_req(1'b1, 32'h10, 32'hDEADBEEF, 5'd3);
        push_req(1'b0, 32'h10, 32'h0,        5'd4);
        drain();

        // 2: misaligned and out-of-range accesses leave memory untouched
        push_req(1'b1, 32'h0,    32'h11111111, 5'd1);
        push_req(1'b0, 32'h13,   32'h0,        5'd2);
        push_req(1'b0, 32'h1000, 32'h0,        5'd5);
        push_req(1'b1, 32'h1002, 32'hBAD0BAD0, 5'd6);
        push_req(1'b1, 32'h1000, 32'hCAFEF00D, 5'd7);
        push_req(1'b0, 32'h0,    32'h0,        5'd8);
        push_req(1'b0, 32'h10,   32'h0,        5'd9);
        drain();

        // 3: response back-pressure caps requests in flight at RSP_DEPTH
        for (int i = 0; i < 4; i++) begin
            push_req(1'b0, 32'(32'h20 + i * 4), 32'h0, 5'(10 + i));
        end
        dut_acc = 0;
        repeat (6) cycle(1'b1, 1'b0);
        check("t3_accepts", dut_acc, RSP_DEPTH);
        check("t3_ready_low", req_ready_o, 0);
        drain();

        // 4: continuous request stream with the response side always ready
        for (int i = 0; i < 20; i++) begin
            push_req(1'b0, 32'(i * 4), 32'h0, 5'(i));
        end
        dut_acc   = 0;
        model_acc = 0;
        repeat (20) cycle(1'b1, 1'b1);
        check("t4_accepts", dut_acc, model_acc);
        drain();

        // 5: reset with two responses pending, then read back stored data
        push_req(1'b0, 32'h10, 32'h0, 5'd20);
        push_req(1'b0, 32'h0,  32'h0, 5'd21);
        repeat (3) cycle(1'b1, 1'b0);
        check("t5_pending", rsp_valid_o, 1);
        #2;
        reset       = 1'b1;
        req_valid_i = 1'b0;
        #1;
        check("t5_rst_valid", rsp_valid_o, 0);
        check("t5_rst_ready", req_ready_o, 1);
        check("t5_rst_data",  rsp_data_o,  0);
        check("t5_rst_tag",   rsp_tag_o,   0);
        check("t5_rst_err",   rsp_err_o,   0);
        exp_q.delete();
        pending.delete();
        @(negedge clk);
        #2;
        reset = 1'b0;
        push_req(1'b0, 32'h10, 32'h0, 5'd22);
        push_req(1'b0, 32'h0,  32'h0, 5'd23);
        drain();

        // 6: random traffic with random valid/ready
        for (int i = 0; i < 10000; i++) begin
            w = $urandom_range(0, 63);
            k = $urandom_range(0, 99);
            if (k < 80)      a = 32'(w * 4);
            else if (k < 90) a = 32'(w * 4 + $urandom_range(1, 3));
            else             a = 32'h1000 | $urandom;
            push_req($urandom_range(0, 1) == 1, a, $urandom, 5'($urandom_range(0, 31)));
        end
        for (int i = 0; i < 60000 && pending.size() > 0; i++) begin
            cycle($urandom_range(0, 99) < 75, $urandom_range(0, 99) < 70);
        end
        check("t6_all_issued", pending.size(), 0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
